// File: rtl/temp_burst_pkg.sv
// Shared state type and default parameters for the burst-count receiver.
package temp_burst_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } burst_state_e;

    localparam int DEF_N_CH       = 4;
    localparam int DEF_CNT_W      = 16;
    localparam int DEF_CLK_PER_US = 50;
    localparam int DEF_GAP_MS     = 2;
    localparam int DEF_TMO_MS     = 100;
    localparam int DEF_FILT_LEN   = 4;
    localparam int US_PER_MS      = 1000;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/temp_dq_filt.sv
// One DQ line: 2-FF synchroniser, run-length glitch filter and rising-edge flag.
module temp_dq_filt
    import temp_burst_pkg::*;
#(
    parameter int FILT_LEN = DEF_FILT_LEN
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic dq_i,
    output logic edge_o
);

    localparam int FW = cw(FILT_LEN);
    localparam logic [FW-1:0] LAST = FW'(FILT_LEN - 1);

    logic          s1_q;
    logic          s2_q;
    logic          filt_q;
    logic          filt_d;
    logic          prev_q;
    logic          edge_q;
    logic [FW-1:0] cnt_q;
    logic [FW-1:0] cnt_d;

    // cnt_q counts consecutive samples disagreeing with the filtered level.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (s2_q != filt_q) begin
            if (cnt_q == LAST) begin
                filt_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            filt_q <= 1'b0;
            cnt_q  <= '0;
            prev_q <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            s1_q   <= dq_i;
            s2_q   <= s1_q;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
            prev_q <= filt_q;
            edge_q <= filt_q & ~prev_q;
        end
    end

    assign edge_o = edge_q;

endmodule

// File: rtl/temp_burst_rx.sv
// Multi-channel pulse-burst counter: counts filtered DQ pulses per burst,
// publishes the count after an idle gap and flags absent or saturating sensors.
module temp_burst_rx
    import temp_burst_pkg::*;
#(
    parameter int N_CH       = DEF_N_CH,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int CLK_PER_US = DEF_CLK_PER_US,
    parameter int GAP_MS     = DEF_GAP_MS,
    parameter int TMO_MS     = DEF_TMO_MS,
    parameter int FILT_LEN   = DEF_FILT_LEN
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [N_CH-1:0]       TEMP_DQ,
    input  logic                  ERR_CLR,
    output logic [N_CH*CNT_W-1:0] TEMP_DATA,
    output logic [N_CH-1:0]       TEMP_VLD,
    output logic [N_CH-1:0]       TEMP_ERR,
    output logic [N_CH-1:0]       TEMP_OVF
);

    localparam int UW = cw(CLK_PER_US);
    localparam int MW = cw(US_PER_MS);
    localparam int GW = cw(GAP_MS + 1);
    localparam int IW = cw(TMO_MS + 1);

    localparam logic [CNT_W-1:0] CMAX  = '1;
    localparam logic [GW-1:0]    GLAST = GW'(GAP_MS - 1);
    localparam logic [IW-1:0]    IMAX  = IW'(TMO_MS);

    logic [UW-1:0] us_q;
    logic [UW-1:0] us_d;
    logic [MW-1:0] ms_q;
    logic [MW-1:0] ms_d;
    logic          us_tick;
    logic          ms_tick;

    assign us_tick = (us_q == UW'(CLK_PER_US - 1));
    assign ms_tick = us_tick && (ms_q == MW'(US_PER_MS - 1));
    assign us_d    = us_tick ? '0 : us_q + 1'b1;
    assign ms_d    = ms_tick ? '0 : (us_tick ? ms_q + 1'b1 : ms_q);

    logic [N_CH-1:0] pulse;

    for (genvar g = 0; g < N_CH; g++) begin : g_filt
        temp_dq_filt #(
            .FILT_LEN(FILT_LEN)
        ) u_filt (
            .clk_i (CLK),
            .rst_ni(RST),
            .dq_i  (TEMP_DQ[g]),
            .edge_o(pulse[g])
        );
    end

    burst_state_e     st_q   [N_CH];
    burst_state_e     st_d   [N_CH];
    logic [CNT_W-1:0] cnt_q  [N_CH];
    logic [CNT_W-1:0] cnt_d  [N_CH];
    logic [CNT_W-1:0] data_q [N_CH];
    logic [CNT_W-1:0] data_d [N_CH];
    logic [GW-1:0]    gap_q  [N_CH];
    logic [GW-1:0]    gap_d  [N_CH];
    logic [IW-1:0]    idle_q [N_CH];
    logic [IW-1:0]    idle_d [N_CH];
    logic [N_CH-1:0]  vld_q;
    logic [N_CH-1:0]  vld_d;
    logic [N_CH-1:0]  err_q;
    logic [N_CH-1:0]  err_d;
    logic [N_CH-1:0]  ovf_q;
    logic [N_CH-1:0]  ovf_d;

    // Clears are applied first so that a coincident set overrides them.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            st_d[i]   = st_q[i];
            cnt_d[i]  = cnt_q[i];
            gap_d[i]  = gap_q[i];
            data_d[i] = data_q[i];
            idle_d[i] = idle_q[i];
            vld_d[i]  = 1'b0;
            err_d[i]  = ERR_CLR ? 1'b0 : err_q[i];
            ovf_d[i]  = ERR_CLR ? 1'b0 : ovf_q[i];
            unique case (st_q[i])
                ST_IDLE: begin
                    if (pulse[i]) begin
                        st_d[i]  = ST_BURST;
                        cnt_d[i] = CNT_W'(1);
                        gap_d[i] = '0;
                    end
                end
                ST_BURST: begin
                    if (pulse[i]) begin
                        gap_d[i] = '0;
                        if (cnt_q[i] == CMAX) begin
                            ovf_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end else if (ms_tick) begin
                        if (gap_q[i] == GLAST) begin
                            data_d[i] = cnt_q[i];
                            vld_d[i]  = 1'b1;
                            err_d[i]  = 1'b0;
                            cnt_d[i]  = '0;
                            gap_d[i]  = '0;
                            st_d[i]   = ST_IDLE;
                        end else begin
                            gap_d[i] = gap_q[i] + 1'b1;
                        end
                    end
                end
                default: st_d[i] = ST_IDLE;
            endcase
            if (pulse[i]) begin
                idle_d[i] = '0;
            end else if (ms_tick && idle_q[i] != IMAX) begin
                idle_d[i] = idle_q[i] + 1'b1;
                if (idle_q[i] == IMAX - 1'b1) begin
                    err_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            us_q  <= '0;
            ms_q  <= '0;
            vld_q <= '0;
            err_q <= '0;
            ovf_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                st_q[i]   <= ST_IDLE;
                cnt_q[i]  <= '0;
                data_q[i] <= '0;
                gap_q[i]  <= '0;
                idle_q[i] <= '0;
            end
        end else begin
            us_q  <= us_d;
            ms_q  <= ms_d;
            vld_q <= vld_d;
            err_q <= err_d;
            ovf_q <= ovf_d;
            for (int i = 0; i < N_CH; i++) begin
                st_q[i]   <= st_d[i];
                cnt_q[i]  <= cnt_d[i];
                data_q[i] <= data_d[i];
                gap_q[i]  <= gap_d[i];
                idle_q[i] <= idle_d[i];
            end
        end
    end

    always_comb begin
        TEMP_DATA = '0;
        for (int i = 0; i < N_CH; i++) begin
            TEMP_DATA[i*CNT_W +: CNT_W] = data_q[i];
        end
    end

    assign TEMP_VLD = vld_q;
    assign TEMP_ERR = err_q;
    assign TEMP_OVF = ovf_q;

endmodule

// File: tb/tb_temp_burst_rx.sv
// Directed bench: table of bursts on two receivers (16-bit and 4-bit counts)
// plus timeout, overflow-clear and mid-burst reset sequences.
module tb_temp_burst_rx;

    localparam int NCH = 4;
    localparam int CWA = 16;
    localparam int CWB = 4;
    localparam int CPU = 1;
    localparam int GAP = 3;
    localparam int TMO = 20;
    localparam int FL  = 4;
    localparam int MS  = 1000 * CPU;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clr_a = 1'b0;
    logic clr_b = 1'b0;
    logic [NCH-1:0] dq_a = '0;
    logic [NCH-1:0] dq_b = '0;
    logic [NCH*CWA-1:0] data_a;
    logic [NCH*CWB-1:0] data_b;
    logic [NCH-1:0] vld_a, err_a, ovf_a;
    logic [NCH-1:0] vld_b, err_b, ovf_b;

    int checks = 0;
    int errors = 0;
    int sa [NCH];
    int sb [NCH];
    int exp_a [NCH];
    int exp_b [NCH];

    always #5 clk = ~clk;

    temp_burst_rx #(
        .N_CH(NCH), .CNT_W(CWA), .CLK_PER_US(CPU),
        .GAP_MS(GAP), .TMO_MS(TMO), .FILT_LEN(FL)
    ) u_dut_a (
        .CLK(clk), .RST(rst_n), .TEMP_DQ(dq_a), .ERR_CLR(clr_a),
        .TEMP_DATA(data_a), .TEMP_VLD(vld_a),
        .TEMP_ERR(err_a), .TEMP_OVF(ovf_a)
    );

    temp_burst_rx #(
        .N_CH(NCH), .CNT_W(CWB), .CLK_PER_US(CPU),
        .GAP_MS(GAP), .TMO_MS(TMO), .FILT_LEN(FL)
    ) u_dut_b (
        .CLK(clk), .RST(rst_n), .TEMP_DQ(dq_b), .ERR_CLR(clr_b),
        .TEMP_DATA(data_b), .TEMP_VLD(vld_b),
        .TEMP_ERR(err_b), .TEMP_OVF(ovf_b)
    );

    always @(negedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (vld_a[i]) sa[i]++;
            if (vld_b[i]) sb[i]++;
        end
    end

    typedef struct {
        bit b;
        int ch;
        int n;
        int split;
        bit gl;
        int exp;
        bit ovf;
    } vec_t;

    vec_t tbl [6];

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic set_dq(input bit b, input int ch, input bit v);
        if (b) dq_b[ch] = v;
        else dq_a[ch] = v;
    endtask

    task automatic pulses(input bit b, input int ch, input int n,
                          input bit gl);
        for (int k = 0; k < n; k++) begin
            set_dq(b, ch, 1'b1);
            cyc(5);
            set_dq(b, ch, 1'b0);
            cyc(5);
            if (gl) begin
                set_dq(b, ch, 1'b1);
                cyc(FL - 1);
                set_dq(b, ch, 1'b0);
                cyc(5);
            end
        end
    endtask

    function automatic int strobes(input bit b, input int ch);
        return b ? sb[ch] : sa[ch];
    endfunction

    task automatic check_data(input string nm);
        for (int i = 0; i < NCH; i++) begin
            check({nm, "_data_a"}, 64'(data_a[i*CWA +: CWA]), 64'(exp_a[i]));
            check({nm, "_data_b"}, 64'(data_b[i*CWB +: CWB]), 64'(exp_b[i]));
        end
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_data_a"}, 64'(data_a), 64'd0);
        check({nm, "_data_b"}, 64'(data_b), 64'd0);
        check({nm, "_vld"}, 64'({vld_a, vld_b}), 64'd0);
        check({nm, "_err"}, 64'({err_a, err_b}), 64'd0);
        check({nm, "_ovf"}, 64'({ovf_a, ovf_b}), 64'd0);
    endtask

    initial begin
        vec_t v;
        int s0;

        tbl[0] = '{0, 0, 37, 0, 0, 37, 0};
        tbl[1] = '{0, 1, 10, 5, 0, 10, 0};
        tbl[2] = '{0, 2, 12, 0, 1, 12, 0};
        tbl[3] = '{1, 0, 7, 0, 0, 7, 0};
        tbl[4] = '{1, 3, 20, 0, 0, 15, 1};
        tbl[5] = '{0, 0, 3, 0, 0, 3, 0};
        for (int i = 0; i < NCH; i++) begin
            exp_a[i] = 0;
            exp_b[i] = 0;
        end

        cyc(3);
        check_zero("reset");
        rst_n = 1'b1;
        cyc(2);

        for (int t = 0; t < 6; t++) begin
            v  = tbl[t];
            s0 = strobes(v.b, v.ch);
            if (v.split > 0) begin
                pulses(v.b, v.ch, v.split, v.gl);
                cyc(1500 * CPU);
                pulses(v.b, v.ch, v.n - v.split, v.gl);
            end else begin
                pulses(v.b, v.ch, v.n, v.gl);
            end
            cyc(MS * (GAP - 1) - 100);
            check("early_vld", 64'(strobes(v.b, v.ch) - s0), 64'd0);
            cyc(1200);
            check("burst_vld", 64'(strobes(v.b, v.ch) - s0), 64'd1);
            if (v.b) exp_b[v.ch] = v.exp;
            else exp_a[v.ch] = v.exp;
            check_data("burst");
            check("burst_ovf", 64'(v.b ? ovf_b[v.ch] : ovf_a[v.ch]),
                  64'(v.ovf));
        end

        check("ovf_b_all", 64'(ovf_b), 64'b1000);
        clr_b = 1'b1;
        cyc(1);
        clr_b = 1'b0;
        cyc(1);
        check("ovf_clr", 64'(ovf_b), 64'd0);
        check("ovf_clr_data", 64'(data_b[3*CWB +: CWB]), 64'd15);

        rst_n = 1'b0;
        cyc(2);
        check_zero("rst2");
        for (int i = 0; i < NCH; i++) begin
            exp_a[i] = 0;
            exp_b[i] = 0;
        end
        rst_n = 1'b1;
        cyc(TMO * MS - 500);
        check("err_early", 64'(err_a), 64'd0);
        cyc(1000);
        check("err_tmo", 64'(err_a), 64'hF);
        s0 = sa[0];
        pulses(1'b0, 0, 8, 1'b0);
        cyc(MS * GAP + 100);
        check("tmo_vld", 64'(sa[0] - s0), 64'd1);
        exp_a[0] = 8;
        check_data("tmo");
        check("err_after", 64'(err_a), 64'b1110);

        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        s0 = sa[1];
        pulses(1'b0, 1, 6, 1'b0);
        cyc(200);
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        for (int i = 0; i < NCH; i++) begin
            exp_a[i] = 0;
            exp_b[i] = 0;
        end
        cyc(3);
        rst_n = 1'b1;
        cyc(MS * GAP + 1000);
        check("midrst_novld", 64'(sa[1] - s0), 64'd0);
        check("midrst_data", 64'(data_a), 64'd0);
        s0 = sa[1];
        pulses(1'b0, 1, 4, 1'b0);
        cyc(MS * GAP + 100);
        check("post_vld", 64'(sa[1] - s0), 64'd1);
        exp_a[1] = 4;
        check_data("post");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
